// File: rtl/cga_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : cga_text_writer
// Purpose  : Byte-stream text console writing char/attr pairs into the 16K
//            CGA text buffer. One byte per valid/ready handshake. Handles
//            CR, LF, BS and FF, wraps at end of line and scrolls the screen
//            up by one row when a line feed happens on the last row.
//            Owns the CPU-side port of the CGA RAM while active.
// Ports    : i_clock      system clock, rising edge
//            i_reset_n    synchronous reset, active low
//            i_data       byte to display
//            i_valid      i_data is valid
//            o_ready      a byte can be accepted this cycle
//            o_address    CGA RAM address (14 bit, wraps modulo 16K)
//            o_out        CGA RAM write data
//            i_in         CGA RAM read data, valid one clock after address
//            o_we         CGA RAM write strobe, one clock per byte
//            o_cursor_x   current column 0..COLS-1
//            o_cursor_y   current row 0..ROWS-1
//            o_busy       high whenever the FSM is not idle
// Options  : CGA_ATTR_ESC_EN - when defined, 8'h1B arms an escape and the
//            next accepted byte becomes the attribute. When undefined, 8'h1B
//            is printed like any other glyph.
// Revision : 1.0 - initial release
// ============================================================================
module cga_text_writer #(
    parameter int          COLS = 80,
    parameter int          ROWS = 25,
    parameter logic [7:0]  ATTR = 8'h07,
    parameter logic [13:0] BASE = 14'h0
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [13:0] o_address,
    output logic [7:0]  o_out,
    input  logic [7:0]  i_in,
    output logic        o_we,
    output logic [6:0]  o_cursor_x,
    output logic [4:0]  o_cursor_y,
    output logic        o_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [6:0]  c_X_MAX     = 7'(COLS - 1);
    localparam logic [4:0]  c_Y_MAX     = 5'(ROWS - 1);
    localparam logic [13:0] c_ROW_BYTES = 14'(2 * COLS);
    localparam logic [13:0] c_LAST_ROW  = 14'(2 * COLS * (ROWS - 1));
    localparam logic [13:0] c_SCR_LAST  = 14'(2 * COLS * (ROWS - 1) - 1);
    localparam logic [13:0] c_CLR_LAST  = 14'(2 * COLS - 1);
    localparam logic [13:0] c_CLS_LAST  = 14'(2 * COLS * ROWS - 1);
    localparam logic [7:0]  c_CR        = 8'h0D;
    localparam logic [7:0]  c_LF        = 8'h0A;
    localparam logic [7:0]  c_BS        = 8'h08;
    localparam logic [7:0]  c_FF        = 8'h0C;
    localparam logic [7:0]  c_SPACE     = 8'h20;
`ifdef CGA_ATTR_ESC_EN
    localparam logic [7:0]  c_ESC       = 8'h1B;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUT_CH  = 3'd1,
        PUT_AT  = 3'd2,
        ADV     = 3'd3,
        SCR_RD  = 3'd4,
        SCR_WR  = 3'd5,
        SCR_CLR = 3'd6,
        CLS     = 3'd7
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [6:0]  r_x;
    logic [4:0]  r_y;
    logic [7:0]  r_attr;
    logic [7:0]  r_char;
    logic [13:0] r_cnt;     // byte index for scroll copy, last-row clear and CLS
    logic        r_ready;
`ifdef CGA_ATTR_ESC_EN
    logic        r_esc;     // escape armed: next byte is an attribute
`endif

    // ------------------------------------------------------------------------
    // Next-state values and RAM port drive
    // ------------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [6:0]  w_x_nxt;
    logic [4:0]  w_y_nxt;
    logic [7:0]  w_attr_nxt;
    logic [7:0]  w_char_nxt;
    logic [13:0] w_cnt_nxt;
`ifdef CGA_ATTR_ESC_EN
    logic        w_esc_nxt;
`endif
    logic        w_accept;
    logic        w_dispatch;
    logic        w_we;
    logic [13:0] w_addr;
    logic [7:0]  w_out;
    logic [13:0] w_cell_idx;
    logic [13:0] w_cell_addr;
    logic [7:0]  w_fill;

    assign w_accept    = i_valid & r_ready;
    // Cell index y*COLS+x; each cell is a char byte followed by an attr byte.
    assign w_cell_idx  = 14'(r_y) * 14'(COLS) + 14'(r_x);
    assign w_cell_addr = BASE + (w_cell_idx << 1);
    // Blank fill alternates space / attribute, keyed on byte parity.
    assign w_fill      = r_cnt[0] ? r_attr : c_SPACE;

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_attr_nxt  = r_attr;
        w_char_nxt  = r_char;
        w_cnt_nxt   = r_cnt;
`ifdef CGA_ATTR_ESC_EN
        w_esc_nxt   = r_esc;
`endif
        w_dispatch  = w_accept;
        w_we        = 1'b0;
        w_addr      = 14'h0;
        w_out       = 8'h0;

        case (r_state)
            IDLE: begin
`ifdef CGA_ATTR_ESC_EN
                // Escape handling takes priority over every code, FF included.
                if (w_accept) begin
                    if (r_esc) begin
                        w_attr_nxt = i_data;
                        w_esc_nxt  = 1'b0;
                        w_dispatch = 1'b0;
                    end else if (i_data == c_ESC) begin
                        w_esc_nxt  = 1'b1;
                        w_dispatch = 1'b0;
                    end
                end
`endif
                if (w_dispatch) begin
                    case (i_data)
                        c_CR: begin
                            w_x_nxt = 7'd0;
                        end
                        c_LF: begin
                            if (r_y < c_Y_MAX) begin
                                w_y_nxt = r_y + 5'd1;
                            end else begin
                                w_cnt_nxt   = 14'd0;
                                w_state_nxt = SCR_RD;
                            end
                        end
                        c_BS: begin
                            if (r_x != 7'd0) begin
                                w_x_nxt = r_x - 7'd1;
                            end
                        end
                        c_FF: begin
                            w_cnt_nxt   = 14'd0;
                            w_state_nxt = CLS;
                        end
                        default: begin
                            w_char_nxt  = i_data;
                            w_state_nxt = PUT_CH;
                        end
                    endcase
                end
            end

            PUT_CH: begin
                w_we        = 1'b1;
                w_addr      = w_cell_addr;
                w_out       = r_char;
                w_state_nxt = PUT_AT;
            end

            PUT_AT: begin
                w_we        = 1'b1;
                w_addr      = w_cell_addr + 14'd1;
                w_out       = r_attr;
                w_state_nxt = ADV;
            end

            ADV: begin
                w_state_nxt = IDLE;
                if (r_x < c_X_MAX) begin
                    w_x_nxt = r_x + 7'd1;
                end else begin
                    // End of line: wrap and apply an implicit line feed.
                    w_x_nxt = 7'd0;
                    if (r_y < c_Y_MAX) begin
                        w_y_nxt = r_y + 5'd1;
                    end else begin
                        w_cnt_nxt   = 14'd0;
                        w_state_nxt = SCR_RD;
                    end
                end
            end

            SCR_RD: begin
                // Present the source one row down; data returns next cycle.
                w_addr      = BASE + c_ROW_BYTES + r_cnt;
                w_state_nxt = SCR_WR;
            end

            SCR_WR: begin
                w_we   = 1'b1;
                w_addr = BASE + r_cnt;
                w_out  = i_in;
                if (r_cnt == c_SCR_LAST) begin
                    w_cnt_nxt   = 14'd0;
                    w_state_nxt = SCR_CLR;
                end else begin
                    w_cnt_nxt   = r_cnt + 14'd1;
                    w_state_nxt = SCR_RD;
                end
            end

            SCR_CLR: begin
                w_we   = 1'b1;
                w_addr = BASE + c_LAST_ROW + r_cnt;
                w_out  = w_fill;
                if (r_cnt == c_CLR_LAST) begin
                    w_cnt_nxt   = 14'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 14'd1;
                end
            end

            CLS: begin
                w_we   = 1'b1;
                w_addr = BASE + r_cnt;
                w_out  = w_fill;
                if (r_cnt == c_CLS_LAST) begin
                    w_cnt_nxt   = 14'd0;
                    w_x_nxt     = 7'd0;
                    w_y_nxt     = 5'd0;
                    w_attr_nxt  = ATTR;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 14'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_x     <= 7'd0;
            r_y     <= 5'd0;
            r_attr  <= ATTR;
            r_char  <= 8'h0;
            r_cnt   <= 14'd0;
            r_ready <= 1'b0;
`ifdef CGA_ATTR_ESC_EN
            r_esc   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_attr  <= w_attr_nxt;
            r_char  <= w_char_nxt;
            r_cnt   <= w_cnt_nxt;
            // Registered so ready stays low through the reset cycle and
            // rises one clock after release.
            r_ready <= (w_state_nxt == IDLE);
`ifdef CGA_ATTR_ESC_EN
            r_esc   <= w_esc_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_ready    = r_ready;
    assign o_we       = w_we;
    assign o_address  = w_addr;
    assign o_out      = w_out;
    assign o_cursor_x = r_x;
    assign o_cursor_y = r_y;
    assign o_busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cga_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cga_text_writer
// Purpose  : Self-checking bench for cga_text_writer. Models the CGA RAM and
//            keeps a behavioural console model (screen array + cursor) that
//            the RAM contents and cursor are compared against.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cga_text_writer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [13:0] address;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        we;
    logic [6:0]  cx;
    logic [4:0]  cy;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    cga_text_writer dut (
        .i_clock    (clk),
        .i_reset_n  (reset_n),
        .i_data     (data),
        .i_valid    (valid),
        .o_ready    (ready),
        .o_address  (address),
        .o_out      (wdata),
        .i_in       (rdata),
        .o_we       (we),
        .o_cursor_x (cx),
        .o_cursor_y (cy),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CGA RAM: synchronous write, read data one clock after address.
    logic [7:0]  ram [0:16383];
    logic [21:0] wlog [$];
    always @(posedge clk) begin
        if (we === 1'b1) begin
            ram[address] <= wdata;
            wlog.push_back({address, wdata});
        end
        rdata <= ram[address];
    end

    // ------------------------------------------------------------------------
    // Reference console model
    // ------------------------------------------------------------------------
    logic [7:0] ref_mem [0:16383];
    int         rx, ry;
    logic [7:0] rattr;
    bit         resc;

    function automatic void ref_reset();
        rx = 0; ry = 0; rattr = 8'h07; resc = 1'b0;
    endfunction

    function automatic void ref_lf();
        if (ry < 24) begin
            ry++;
        end else begin
            for (int i = 0; i < 3840; i++) ref_mem[i] = ref_mem[i + 160];
            for (int i = 3840; i < 4000; i += 2) begin
                ref_mem[i] = 8'h20; ref_mem[i + 1] = rattr;
            end
        end
    endfunction

    function automatic void ref_apply(input logic [7:0] b);
        int a;
`ifdef CGA_ATTR_ESC_EN
        if (resc) begin rattr = b; resc = 1'b0; return; end
        if (b == 8'h1B) begin resc = 1'b1; return; end
`endif
        case (b)
            8'h0D: rx = 0;
            8'h0A: ref_lf();
            8'h08: if (rx > 0) rx--;
            8'h0C: begin
                for (int i = 0; i < 4000; i += 2) begin
                    ref_mem[i] = 8'h20; ref_mem[i + 1] = rattr;
                end
                rx = 0; ry = 0; rattr = 8'h07;
            end
            default: begin
                a = (ry * 80 + rx) * 2;
                ref_mem[a] = b; ref_mem[a + 1] = rattr;
                if (rx < 79) rx++;
                else begin rx = 0; ref_lf(); end
            end
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offer a byte, wait for it to be taken, then wait until idle.
    task automatic send_byte(input logic [7:0] b, output int cyc);
        int n = 0;
        valid = 1'b1; data = b; cyc = 0;
        while (ready !== 1'b1 && n < 20000) begin tick(); n++; end
        if (n >= 20000) begin
            checks++; failures++;
            $display("FAIL send_accept_timeout: byte %02h not accepted", b);
            valid = 1'b0;
            return;
        end
        tick();
        valid = 1'b0; data = 8'($urandom);
        ref_apply(b);
        while (busy !== 1'b0 && cyc < 20000) begin tick(); cyc++; end
        if (cyc >= 20000) begin
            checks++; failures++;
            $display("FAIL send_idle_timeout: byte %02h busy=%b", b, busy);
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0, first = -1;
        for (int i = 0; i < 16384; i++) begin
            if (ram[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: %0d bytes differ, first @%04h got %02h expected %02h",
                     name, bad, first, ram[first], ref_mem[first]);
        end
    endtask

    task automatic check_cursor(input string name);
        checks++;
        if (cx !== 7'(rx) || cy !== 5'(ry)) begin
            failures++;
            $display("FAIL %s: cursor got (%0d,%0d) expected (%0d,%0d)", name, cx, cy, rx, ry);
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        for (int i = 0; i < 16384; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ref_reset();
        reset_n = 1'b0; valid = 1'b0; data = 8'h00;
        repeat (3) tick();
        checks++;
        if (ready !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b we=%b busy=%b expected 0 0 0", ready, we, busy);
        end
        checks++;
        if (address !== 14'h0 || wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_bus: address=%04h out=%02h expected 0000 00", address, wdata);
        end
        check_cursor("reset_cursor");
        reset_n = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
    endtask

    task automatic test_put_char();
        valid = 1'b1; data = 8'h41;
        tick();
        valid = 1'b0;
        ref_apply(8'h41);
        checks++;
        if ({we, address, wdata} !== {1'b1, 14'h0000, 8'h41} || ready !== 1'b0) begin
            failures++;
            $display("FAIL put_char_wr: we=%b addr=%04h out=%02h ready=%b expected 1 0000 41 0",
                     we, address, wdata, ready);
        end
        tick();
        checks++;
        if ({we, address, wdata} !== {1'b1, 14'h0001, 8'h07}) begin
            failures++;
            $display("FAIL put_attr_wr: we=%b addr=%04h out=%02h expected 1 0001 07", we, address, wdata);
        end
        tick();
        checks++;
        if (we !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL put_adv: we=%b ready=%b expected 0 0", we, ready);
        end
        tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL put_ready_latency: ready=%b expected 1", ready);
        end
        check_cursor("put_cursor");
    endtask

    task automatic test_wrap();
        int c;
        send_byte(8'h0D, c);
        repeat (3) send_byte(8'h0A, c);
        for (int i = 0; i < 79; i++) send_byte(8'($urandom_range(33, 126)), c);
        check_cursor("wrap_pre");
        wlog.delete();
        send_byte(8'h5A, c);
        checks++;
        if (wlog.size() != 2 || wlog[0] !== {14'h027E, 8'h5A} || wlog[1] !== {14'h027F, 8'h07}) begin
            failures++;
            $display("FAIL wrap_writes: n=%0d first=%06h expected 2 writes 027E:5A 027F:07",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 22'h0);
        end
        check_cursor("wrap_cursor");
        check_mem("wrap_mem");
    endtask

    task automatic test_scroll();
        int c;
        logic [7:0] moved;
        for (int i = 0; i < 30 && ry < 24; i++) send_byte(8'h0A, c);
        moved = ram[160];
        send_byte(8'h0A, c);
        checks++;
        if (c != 7840) begin
            failures++;
            $display("FAIL scroll_cycles: got %0d expected 7840", c);
        end
        checks++;
        if (ram[0] !== moved || ram[3840] !== 8'h20 || ram[3999] !== 8'h07) begin
            failures++;
            $display("FAIL scroll_bytes: @0000=%02h exp %02h @0F00=%02h exp 20 @0F9F=%02h exp 07",
                     ram[0], moved, ram[3840], ram[3999]);
        end
        check_cursor("scroll_cursor");
        check_mem("scroll_mem");
    endtask

    task automatic test_clear();
        int n = 0, bad = 0;
        valid = 1'b1; data = 8'h0C;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
        wlog.delete();
        tick();
        ref_apply(8'h0C);
        data = 8'h51;               // held valid throughout the clear
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin tick(); n++; end
        checks++;
        if (n != 4000) begin
            failures++;
            $display("FAIL clear_cycles: got %0d expected 4000", n);
        end
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {14'(i), (i % 2 == 1) ? 8'h07 : 8'h20}) bad++;
        checks++;
        if (wlog.size() != 4000 || bad != 0) begin
            failures++;
            $display("FAIL clear_writes: n=%0d bad=%0d expected 4000 0", wlog.size(), bad);
        end
        check_cursor("clear_cursor");
        tick();
        valid = 1'b0;
        ref_apply(8'h51);
        checks++;
        if ({we, address, wdata} !== {1'b1, 14'h0000, 8'h51}) begin
            failures++;
            $display("FAIL clear_held_byte: we=%b addr=%04h out=%02h expected 1 0000 51",
                     we, address, wdata);
        end
        n = 0;
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end
        check_mem("clear_mem");
    endtask

    task automatic test_backspace();
        int c;
        send_byte(8'h0D, c);
        wlog.delete();
        send_byte(8'h08, c);
        checks++;
        if (wlog.size() != 0 || cx !== 7'd0) begin
            failures++;
            $display("FAIL bs_at_zero: writes=%0d x=%0d expected 0 0", wlog.size(), cx);
        end
        send_byte(8'h42, c);
        send_byte(8'h08, c);
        send_byte(8'h43, c);
        checks++;
        if (ram[0] !== 8'h43 || ram[1] !== 8'h07) begin
            failures++;
            $display("FAIL bs_overwrite: @0000=%02h @0001=%02h expected 43 07", ram[0], ram[1]);
        end
        check_cursor("bs_cursor");
        check_mem("bs_mem");
    endtask

    task automatic test_escape();
        int c, x0;
        logic [13:0] a0;
        x0 = rx;
        a0 = 14'((ry * 80 + rx) * 2);
        wlog.delete();
        send_byte(8'h1B, c);
        send_byte(8'h1E, c);
        send_byte(8'h58, c);
        checks++;
`ifdef CGA_ATTR_ESC_EN
        if (wlog.size() != 2 || wlog[0] !== {a0, 8'h58} || wlog[1] !== {a0 + 14'd1, 8'h1E}
            || cx !== 7'(x0 + 1)) begin
            failures++;
            $display("FAIL esc_attr: n=%0d x=%0d expected 2 writes and x=%0d", wlog.size(), cx, x0 + 1);
        end
`else
        if (wlog.size() != 6 || wlog[0] !== {a0, 8'h1B} || cx !== 7'(x0 + 3)) begin
            failures++;
            $display("FAIL esc_glyph: n=%0d x=%0d expected 6 writes and x=%0d", wlog.size(), cx, x0 + 3);
        end
`endif
        check_cursor("esc_cursor");
        check_mem("esc_mem");
    endtask

    task automatic test_random();
        int c, r, bad = 0;
        logic [7:0] b;
        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      b = 8'h0D;
            else if (r < 3)  b = 8'h0A;
            else if (r == 3) b = 8'h08;
            else             b = 8'($urandom_range(32, 126));
            send_byte(b, c);
            if (cx !== 7'(rx) || cy !== 5'(ry)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random_cursor: %0d steps mismatched, now (%0d,%0d) expected (%0d,%0d)",
                     bad, cx, cy, rx, ry);
        end
        check_mem("random_mem");
    endtask

    task automatic test_reset_mid_scroll();
        int c, n = 0;
        for (int i = 0; i < 30 && ry < 24; i++) send_byte(8'h0A, c);
        valid = 1'b1; data = 8'h0A;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        valid = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if (we !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL midscroll_reset: we=%b busy=%b ready=%b expected 0 0 0", we, busy, ready);
        end
        ref_reset();
        check_cursor("midscroll_cursor");
        reset_n = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL midscroll_ready: got %b expected 1", ready);
        end
        // RAM is legitimately left partially copied; resync the model to it.
        for (int i = 0; i < 16384; i++) ref_mem[i] = ram[i];
        send_byte(8'h41, c);
        check_mem("midscroll_after");
        check_cursor("midscroll_after_cursor");
    endtask

    initial begin
        reset_n = 1'b0; valid = 1'b0; data = 8'h00;
        test_reset();
        test_put_char();
        test_wrap();
        test_scroll();
        test_clear();
        test_backspace();
        test_escape();
        test_random();
        test_reset_mid_scroll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
